acc_25: RTL



---
 rtl/hevc_acc_pkg.sv | 21 ++
 rtl/acc_25_if.sv | 25 ++
 rtl/acc_25_flux_prio_arbiter.sv | 24 ++
 rtl/acc_25.sv | 100 ++++++++++
 4 files changed

// File: rtl/hevc_acc_pkg.sv
// Shared types and widths for the multi-flux accumulator actors of the HEVC datapath.
package hevc_acc_pkg;

  localparam int DATA_WIDTH_PROD     = 18;
  localparam int DATA_WIDTH_EXT_SIZE = 7;
  localparam int DATA_WIDTH_SUM      = 25;

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } acc_state_t;

  // Everything one flux needs to resume a group after losing arbitration.
  typedef struct packed {
    acc_state_t                            state;
    logic [DATA_WIDTH_EXT_SIZE-1:0]        len;
    logic [DATA_WIDTH_EXT_SIZE-1:0]        cnt;
    logic signed [DATA_WIDTH_SUM-1:0]      acc;
  } acc_ctx_t;

endpackage

// File: rtl/acc_25_if.sv
// Multi-flux FIFO access bundles: per-lane empty/read with a shared data bus on the
// read side, per-lane full with a single tagged write on the write side.
interface read_interface #(
  parameter int FLUX  = 2,
  parameter int WIDTH = 8
);
  logic [FLUX-1:0]  empty;
  logic [FLUX-1:0]  read;
  logic [WIDTH-1:0] dout;

  modport actor (input empty, input dout, output read);
  modport fifo  (output empty, output dout, input read);
endinterface

interface write_interface #(
  parameter int FLUX  = 2,
  parameter int WIDTH = 8
);
  logic [FLUX-1:0]  full;
  logic             write;
  logic [WIDTH-1:0] din;

  modport actor (input full, output write, output din);
  modport fifo  (output full, input write, input din);
endinterface

// File: rtl/acc_25_flux_prio_arbiter.sv
// Fixed-priority flux picker: the lowest-index eligible flux wins every cycle.
// Higher-index fluxes may starve; callers accept that.
module flux_prio_arbiter #(
  parameter  int FLUX      = 2,
  localparam int TAG_WIDTH = $clog2(FLUX)
) (
  input  logic [FLUX-1:0]      elig,
  output logic [TAG_WIDTH-1:0] tag,
  output logic                 valid
);

  // Scan from the top down so the lowest eligible index is the last one written.
  always_comb begin
    tag   = '0;
    valid = 1'b0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      if (elig[i]) begin
        tag   = TAG_WIDTH'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acc_25.sv
// Per-flux group accumulator behind the 9-bit-coefficient multiplier: loads a group
// length per flux, sums len+1 signed products and emits one tagged 25-bit sum.
module acc_25 #(
  parameter  int FLUX                = 2,
  parameter  int DATA_WIDTH_EXT_SIZE = 7,
  parameter  int DATA_WIDTH_PROD     = 18,
  parameter  int DATA_WIDTH_SUM      = 25,
  localparam int TAG_WIDTH           = $clog2(FLUX)
) (
  input  logic          clk,
  input  logic          rst,
  read_interface.actor  read_port_prod,
  read_interface.actor  read_port_ext_size,
  write_interface.actor write_port_sum
);

  import hevc_acc_pkg::*;

  acc_ctx_t                          ctx_q [FLUX];
  acc_ctx_t                          ctx_d [FLUX];
  logic [FLUX-1:0]                   elig;
  logic [TAG_WIDTH-1:0]              tag;
  logic                              grant_valid;
  acc_ctx_t                          sel_ctx;
  logic [DATA_WIDTH_PROD-1:0]        prod_val;
  logic [DATA_WIDTH_EXT_SIZE-1:0]    ext_val;
  logic signed [DATA_WIDTH_SUM-1:0]  sum;
  logic                              unused_tag_bits;

  // The flux is identified by the FIFO lane, so incoming tag bits are dropped.
  assign prod_val = read_port_prod.dout[DATA_WIDTH_PROD-1:0];
  assign ext_val  = read_port_ext_size.dout[DATA_WIDTH_EXT_SIZE-1:0];
  assign unused_tag_bits =
    ^{read_port_prod.dout[DATA_WIDTH_PROD+TAG_WIDTH-1:DATA_WIDTH_PROD],
      read_port_ext_size.dout[DATA_WIDTH_EXT_SIZE+TAG_WIDTH-1:DATA_WIDTH_EXT_SIZE]};

  // A flux can move if it can LOAD, ACC, or finish its group with room downstream.
  always_comb begin
    elig = '0;
    for (int f = 0; f < FLUX; f++) begin
      if (ctx_q[f].state == IDLE) begin
        elig[f] = !read_port_ext_size.empty[f];
      end else if (!read_port_prod.empty[f]) begin
        elig[f] = (ctx_q[f].cnt < ctx_q[f].len) ||
                  ((ctx_q[f].cnt == ctx_q[f].len) && !write_port_sum.full[f]);
      end
    end
  end

  flux_prio_arbiter #(.FLUX(FLUX)) u_arb (
    .elig  (elig),
    .tag   (tag),
    .valid (grant_valid)
  );

  // One shared adder serves whichever flux holds the grant this cycle.
  assign sel_ctx = ctx_q[tag];
  assign sum     = sel_ctx.acc +
                   {{(DATA_WIDTH_SUM-DATA_WIDTH_PROD){prod_val[DATA_WIDTH_PROD-1]}}, prod_val};

  // Next context for the winning flux plus the strobes; every other flux holds.
  always_comb begin
    ctx_d                   = ctx_q;
    read_port_ext_size.read = '0;
    read_port_prod.read     = '0;
    write_port_sum.write    = 1'b0;
    write_port_sum.din      = {tag, sum};
    if (grant_valid && !rst) begin
      if (sel_ctx.state == IDLE) begin
        read_port_ext_size.read[tag] = 1'b1;
        ctx_d[tag].state             = WORK;
        ctx_d[tag].len               = ext_val;
        ctx_d[tag].cnt               = '0;
        ctx_d[tag].acc               = '0;
      end else if (sel_ctx.cnt < sel_ctx.len) begin
        read_port_prod.read[tag] = 1'b1;
        ctx_d[tag].acc           = sum;
        ctx_d[tag].cnt           = sel_ctx.cnt + 1'b1;
      end else begin
        read_port_prod.read[tag] = 1'b1;
        write_port_sum.write     = 1'b1;
        ctx_d[tag].state         = IDLE;
        ctx_d[tag].cnt           = '0;
        ctx_d[tag].acc           = '0;
      end
    end
  end

  // Context registers; reset throws away any partial group.
  always_ff @(posedge clk) begin
    for (int f = 0; f < FLUX; f++) begin
      if (rst) begin
        ctx_q[f] <= '0;
      end else begin
        ctx_q[f] <= ctx_d[f];
      end
    end
  end

endmodule
